// File: rtl/lfsr_waveform_source.sv
// Tick-driven DAC sample source: LFSR noise, sawtooth, triangle or square, with a valid/ready output.
// Define LFSR_WAVEFORM_DITHER_EN to add LFSR dither (DITHER_BITS parameter) to modes 1-3.
module lfsr_waveform_source #(
  parameter int unsigned           LFSR_WIDTH = 32,
  parameter logic [LFSR_WIDTH-1:0] TAP_MASK   = 32'h48000000,
  parameter int unsigned           OUT_WIDTH  = 12,
  parameter int unsigned           DIV_WIDTH  = 30
`ifdef LFSR_WAVEFORM_DITHER_EN
  , parameter int unsigned         DITHER_BITS = 2
`endif
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DIV_WIDTH-1:0]  period,
  input  logic [1:0]            mode,
  input  logic [OUT_WIDTH-1:0]  step,
  input  logic                  seed_load,
  input  logic [LFSR_WIDTH-1:0] seed,
  input  logic                  clr_overrun,
  output logic [OUT_WIDTH-1:0]  sample_out,
  output logic                  sample_valid,
  input  logic                  sample_ready,
  output logic                  overrun,
  output logic                  tick
);

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  localparam logic [OUT_WIDTH-1:0] ONES = '1;

  logic [DIV_WIDTH-1:0]  div_cnt;
  logic [DIV_WIDTH-1:0]  period_m1;
  logic                  tick_int;
  logic [LFSR_WIDTH-1:0] lfsr;
  logic [LFSR_WIDTH-1:0] lfsr_next;
  logic [OUT_WIDTH-1:0]  phase;
  logic [OUT_WIDTH-1:0]  phase_next;
  logic [OUT_WIDTH:0]    up_sum;
  dir_t                  dir;
  dir_t                  dir_next;
  logic [OUT_WIDTH-1:0]  wave;
  logic [OUT_WIDTH-1:0]  sample_next;

  // A period of 0 behaves as 1, so the wrap threshold is clamped at 0.
  assign period_m1 = (period == '0) ? '0 : period - DIV_WIDTH'(1);
  assign tick_int  = enable & ~reset & (div_cnt >= period_m1);
  assign tick      = tick_int;

  always_ff @(posedge clk_in) begin
    if (reset) begin
      div_cnt <= '0;
    end else if (!enable) begin
      div_cnt <= '0;
    end else if (div_cnt >= period_m1) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_WIDTH'(1);
    end
  end

  // Seed load outranks the lock-up guard, which outranks the shift.
  always_comb begin
    lfsr_next = lfsr;
    if (seed_load) begin
      lfsr_next = (seed == '0) ? LFSR_WIDTH'(1) : seed;
    end else if (lfsr == '0) begin
      lfsr_next = LFSR_WIDTH'(1);
    end else if (tick_int) begin
      lfsr_next = {lfsr[LFSR_WIDTH-2:0], ^(lfsr & TAP_MASK)};
    end
  end

  always_comb begin
    up_sum     = {1'b0, phase} + {1'b0, step};
    phase_next = phase;
    dir_next   = dir;
    if (tick_int) begin
      case (mode)
        2'd1, 2'd3: phase_next = up_sum[OUT_WIDTH-1:0];
        2'd2: begin
          if (dir == DIR_UP) begin
            if (up_sum[OUT_WIDTH]) begin
              phase_next = ONES;
              dir_next   = DIR_DOWN;
            end else begin
              phase_next = up_sum[OUT_WIDTH-1:0];
            end
          end else begin
            if (phase < step) begin
              phase_next = '0;
              dir_next   = DIR_UP;
            end else begin
              phase_next = phase - step;
            end
          end
        end
        default: phase_next = phase;
      endcase
    end
  end

  always_comb begin
    case (mode)
      2'd0:    wave = lfsr_next[OUT_WIDTH-1:0];
      2'd3:    wave = phase_next[OUT_WIDTH-1] ? ONES : '0;
      default: wave = phase_next;
    endcase
  end

`ifdef LFSR_WAVEFORM_DITHER_EN
  logic [OUT_WIDTH:0] dither_sum;

  always_comb begin
    dither_sum  = {1'b0, wave} + (OUT_WIDTH+1)'(lfsr_next[DITHER_BITS-1:0]);
    sample_next = wave;
    if (mode != 2'd0) begin
      sample_next = dither_sum[OUT_WIDTH] ? ONES : dither_sum[OUT_WIDTH-1:0];
    end
  end
`else
  assign sample_next = wave;
`endif

  always_ff @(posedge clk_in) begin
    if (reset) begin
      lfsr         <= LFSR_WIDTH'(1);
      phase        <= '0;
      dir          <= DIR_UP;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      lfsr  <= lfsr_next;
      phase <= phase_next;
      dir   <= dir_next;
      // A tick refills the slot even when the old sample leaves this cycle.
      if (tick_int) begin
        sample_out   <= sample_next;
        sample_valid <= 1'b1;
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
      if (tick_int && sample_valid && !sample_ready) begin
        overrun <= 1'b1;
      end else if (clr_overrun) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: doc/lfsr_waveform_source.md
Name: lfsr_waveform_source

Overview:
Parametrised successor to the fixed 32-bit pseudorandom DAC source. It generates one OUT_WIDTH-bit sample per programmable tick in one of four modes: LFSR noise, sawtooth, triangle or square. Samples go to the DAC driver over a valid/ready handshake, and samples dropped because the driver was busy are flagged. The block replaces the inline LFSR, the divider and the edge detector in the top-level waveform generator.

Parameters:
LFSR_WIDTH, 32, LFSR length (min OUT_WIDTH+1)
TAP_MASK, 32'h48000000, feedback taps; feedback bit = XOR of (lfsr & TAP_MASK); the default gives feedback = bit30 ^ bit27
OUT_WIDTH, 12, sample width (DAC code width)
DIV_WIDTH, 30, tick period counter width
DITHER_BITS, 2, LFSR LSBs added in dither mode (only with DITHER_EN)

Ports:
clk_in  input  1  system clock (50 MHz)
reset  input  1  synchronous, active-high reset
enable  input  1  1 = divider runs; 0 = divider held at 0, no ticks
period  input  DIV_WIDTH  tick period in clk_in cycles; 0 is treated as 1
mode  input  2  0 noise, 1 sawtooth, 2 triangle, 3 square
step  input  OUT_WIDTH  phase increment per tick (modes 1-3)
seed_load  input  1  one-cycle pulse: load seed into LFSR
seed  input  LFSR_WIDTH  LFSR seed value
clr_overrun  input  1  clears overrun flag
sample_out  output  OUT_WIDTH  current sample
sample_valid  output  1  sample_out holds an unconsumed sample
sample_ready  input  1  DAC driver accepts sample_out this cycle
overrun  output  1  sticky: a pending sample was overwritten
tick  output  1  one-cycle pulse per sample period

Behaviour:
- Reset (synchronous): lfsr=1, div counter=0, phase=0, tri_dir=up, sample_out=0, sample_valid=0, overrun=0, tick=0.
- Divider: with enable=1, the counter increments each cycle. When counter >= eff_period-1 (eff_period = max(period,1)), the counter resets to 0 and tick pulses for that cycle. Ticks occur every eff_period cycles. Lowering period mid-count causes a wrap on the next cycle. enable=0 forces counter=0 and tick=0.
- The registered tick-cycle update happens at the clock edge ending the tick cycle; the new sample is visible on the next cycle.
- LFSR: on tick, lfsr <= {lfsr[LFSR_WIDTH-2:0], ^(lfsr & TAP_MASK)}. It advances in every mode.
- Seed load: seed_load has priority over the shift. lfsr <= (seed==0) ? 1 : seed. If seed_load coincides with tick, the noise sample uses the loaded value.
- Lock-up guard: if lfsr is ever 0, it loads 1 on the next cycle.
- Phase (mode 1/3), on tick: phase <= phase + step, modulo 2^OUT_WIDTH.
- Triangle (mode 2), on tick:
  - Up: if phase+step > max, phase=max (all ones) and dir=down; else phase += step.
  - Down: if phase < step, phase=0 and dir=up; else phase -= step.
- Sample value per mode:
  - Noise: the updated lfsr[OUT_WIDTH-1:0].
  - Sawtooth and triangle: the updated phase.
  - Square: all ones if the updated phase MSB is 1, else 0.
- Mode change: takes effect at the next tick. phase and tri_dir are not reset. step = 0 holds phase constant.
- Handshake:
  - On tick: sample_out is loaded and sample_valid is set to 1.
  - Transfer: occurs when sample_valid & sample_ready are high at an edge. Without a tick, sample_valid clears; with a tick in the same cycle, sample_valid stays 1 holding the new sample and overrun is not set.
  - Overrun: a tick while sample_valid=1 & sample_ready=0 overwrites sample_out and sets overrun.
  - sample_out is stable while valid and not ready, except for that overwrite case.
- overrun is cleared by clr_overrun. If set and clear coincide, set wins.
- Reset mid-operation: all state returns to reset values on the next edge; no partial transfer completes.

Optional Feature:
Macro LFSR_WAVEFORM_DITHER_EN.
- Defined: in modes 1-3, sample = updated wave value + lfsr[DITHER_BITS-1:0] (the updated LFSR), saturating at all ones. Noise mode is unchanged.
- Undefined: no dither logic; samples are the pure wave values. DITHER_BITS is ignored.

Test Plan:
- Noise, default params, reset, enable=1, period=1, ready=1 -> successive samples 0x002,0x004,0x008,...,0x800, then 0x000; overrun stays 0.
- Sawtooth, step=0x400, period=4 -> tick every 4 cycles; samples 0x400,0x800,0xC00,0x000,0x400.
- Triangle, step=0x600 -> samples 0x600,0xC00,0xFFF,0x9FF,0x3FF,0x000,0x600.
- Square, step=0x800 -> samples alternate 0xFFF,0x000. Separately, seed_load with seed=0 -> lfsr=1.
- Backpressure, ready=0, period=3 -> first tick valid=1, overrun=0; second tick overrun=1, sample_out = second sample. clr_overrun -> 0. Ready on a tick cycle -> valid stays 1 and overrun does not set.
- period=25000 -> ticks exactly 25000 cycles apart. enable=0 for 100 cycles -> no ticks. Reset mid-period -> counter restarts; valid=0, sample_out=0 on the next cycle.
